// File: rtl/commit_trace_buf.sv
// Retirement-trace capture unit for the write-back stage.
// Filters bubbles and stall repeats, counts retired instructions up to a
// programmable limit after an immediate or PC-match trigger, and queues the
// captured entries in a show-ahead FIFO drained over a valid/ready port.
module commit_trace_buf #(
    parameter int          DEPTH       = 16,
    parameter int          MAX_COMMITS = 1200,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] BUBBLE_IR   = 32'hffffffff
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             arm,
    input  logic             trig_mode,
    input  logic [31:0]      trig_pc,
    input  logic [31:0]      wb_pc,
    input  logic [31:0]      wb_ir,
    input  logic             wb_stall,
    input  logic             wb_rf_w,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_wdata,
    output logic             tr_valid,
    input  logic             tr_ready,
    output logic [31:0]      tr_pc,
    output logic [31:0]      tr_ir,
    output logic             tr_rf_w,
    output logic [4:0]       tr_rd,
    output logic [31:0]      tr_wdata,
    output logic [CNT_W-1:0] commit_count,
    output logic [1:0]       state,
    output logic             done,
    output logic             overflow,
    output logic [15:0]      drop_count
);

    localparam int               AW      = $clog2(DEPTH);
    localparam int               EW      = 102;
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_COMMITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             done_reg;
    logic             overflow_reg;
    logic [15:0]      drop_reg;
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head_reg;

    logic             candidate;
    logic             trigger;
    logic             capture;
    logic             arm_ok;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic             last_commit;
    logic             bypass;
    logic             head_load;
    logic [CNT_W-1:0] count_next;
    logic [AW:0]      wr_ptr_next;
    logic [AW:0]      rd_ptr_next;
    logic [EW-1:0]    entry;

    // Capture qualification, FIFO handshake and next-pointer computation
    always_comb begin
        entry     = {wb_pc, wb_ir, wb_rf_w, wb_rd, wb_wdata};
        candidate = !wb_stall && (wb_ir != BUBBLE_IR);
        trigger   = candidate && (!trig_mode || (wb_pc == trig_pc));
        arm_ok    = arm && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
        capture   = 1'b0;
        case (state_reg)
            ST_ARMED:   capture = trigger;
            ST_CAPTURE: capture = candidate;
            default:    capture = 1'b0;
        endcase
        // The triggering instruction always starts the run at one.
        count_next  = (state_reg == ST_ARMED) ? CNT_ONE : (count_reg + CNT_ONE);
        last_commit = (count_next == MAX_C);

        empty = (wr_ptr_reg == rd_ptr_reg);
        full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
        pop   = !empty && tr_ready;
        // A pop frees the slot at the same edge, so full+pop still accepts.
        push  = capture && (!full || pop);
        drop  = capture && full && !pop;

        rd_ptr_next = pop  ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;
        wr_ptr_next = push ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
        // New head is the slot being written this edge: forward it directly.
        bypass    = push && (rd_ptr_next == wr_ptr_reg);
        // Only reload the head when something remains; otherwise hold the
        // last popped entry on the outputs.
        head_load = (rd_ptr_next != wr_ptr_next);
    end

    // Run-control FSM with commit counter, drop statistics and FIFO pointers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            drop_reg     <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else if (arm_ok) begin
            state_reg    <= ST_ARMED;
            count_reg    <= '0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            drop_reg     <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_reg != 16'hffff) begin
                    drop_reg <= drop_reg + 16'd1;
                end
            end
            if (capture) begin
                count_reg <= count_next;
                if (last_commit) begin
                    state_reg <= ST_DONE;
                    done_reg  <= 1'b1;
                end else if (state_reg == ST_ARMED) begin
                    state_reg <= ST_CAPTURE;
                end
            end
        end
    end

    // Entry storage; no reset so it maps onto RAM
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= entry;
        end
    end

    // Show-ahead head register: registered read at the post-pop address
    always_ff @(posedge clk_in) begin
        if (reset) begin
            head_reg <= '0;
        end else if (!arm_ok && head_load) begin
            head_reg <= bypass ? entry : mem[rd_ptr_next[AW-1:0]];
        end
    end

    assign tr_valid     = !empty;
    assign tr_pc        = head_reg[101:70];
    assign tr_ir        = head_reg[69:38];
    assign tr_rf_w      = head_reg[37];
    assign tr_rd        = head_reg[36:32];
    assign tr_wdata     = head_reg[31:0];
    assign commit_count = count_reg;
    assign state        = state_reg;
    assign done         = done_reg;
    assign overflow     = overflow_reg;
    assign drop_count   = drop_reg;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Scoreboard bench for commit_trace_buf: two instances (long run limit and a
// five-commit limit), both with a four-entry FIFO.
module tb_commit_trace_buf;

    localparam logic [31:0] BUB = 32'hffffffff;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        arm_a = 1'b0;
    logic        arm_b = 1'b0;
    logic        trig_mode = 1'b0;
    logic [31:0] trig_pc = 32'h0;
    logic [31:0] wb_pc = 32'h0;
    logic [31:0] wb_ir = BUB;
    logic        wb_stall = 1'b0;
    logic        wb_rf_w = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_wdata = 32'h0;
    logic        tr_ready = 1'b1;

    logic        tr_valid_a, tr_rf_w_a, done_a, overflow_a;
    logic [31:0] tr_pc_a, tr_ir_a, tr_wdata_a;
    logic [4:0]  tr_rd_a;
    logic [15:0] count_a, drop_a;
    logic [1:0]  state_a;

    logic        tr_valid_b, tr_rf_w_b, done_b, overflow_b;
    logic [31:0] tr_pc_b, tr_ir_b, tr_wdata_b;
    logic [4:0]  tr_rd_b;
    logic [15:0] count_b, drop_b;
    logic [1:0]  state_b;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [101:0] q_a[$];
    logic [101:0] q_b[$];

    always #5 clk_in = ~clk_in;

    commit_trace_buf #(.DEPTH(4), .MAX_COMMITS(1200), .CNT_W(16)) dut_a (
        .clk_in(clk_in), .reset(reset), .arm(arm_a), .trig_mode(trig_mode),
        .trig_pc(trig_pc), .wb_pc(wb_pc), .wb_ir(wb_ir), .wb_stall(wb_stall),
        .wb_rf_w(wb_rf_w), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .tr_valid(tr_valid_a), .tr_ready(tr_ready), .tr_pc(tr_pc_a),
        .tr_ir(tr_ir_a), .tr_rf_w(tr_rf_w_a), .tr_rd(tr_rd_a),
        .tr_wdata(tr_wdata_a), .commit_count(count_a), .state(state_a),
        .done(done_a), .overflow(overflow_a), .drop_count(drop_a)
    );

    commit_trace_buf #(.DEPTH(4), .MAX_COMMITS(5), .CNT_W(16)) dut_b (
        .clk_in(clk_in), .reset(reset), .arm(arm_b), .trig_mode(trig_mode),
        .trig_pc(trig_pc), .wb_pc(wb_pc), .wb_ir(wb_ir), .wb_stall(wb_stall),
        .wb_rf_w(wb_rf_w), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .tr_valid(tr_valid_b), .tr_ready(tr_ready), .tr_pc(tr_pc_b),
        .tr_ir(tr_ir_b), .tr_rf_w(tr_rf_w_b), .tr_rd(tr_rd_b),
        .tr_wdata(tr_wdata_b), .commit_count(count_b), .state(state_b),
        .done(done_b), .overflow(overflow_b), .drop_count(drop_b)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [101:0] ent(input logic [31:0] pc, input logic [31:0] ir,
                                         input logic rf_w, input logic [4:0] rd,
                                         input logic [31:0] wd);
        return {pc, ir, rf_w, rd, wd};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drive one WB cycle; expected entries are queued for the chosen instance.
    task automatic issue(input logic [31:0] pc, input logic [31:0] ir, input logic stall,
                         input logic rf_w, input logic [4:0] rd, input logic [31:0] wd,
                         input bit exp_a, input bit exp_b);
        wb_pc = pc; wb_ir = ir; wb_stall = stall;
        wb_rf_w = rf_w; wb_rd = rd; wb_wdata = wd;
        if (exp_a) q_a.push_back(ent(pc, ir, rf_w, rd, wd));
        if (exp_b) q_b.push_back(ent(pc, ir, rf_w, rd, wd));
        tick();
    endtask

    task automatic idle(input int n);
        wb_ir = BUB; wb_stall = 1'b0; wb_rf_w = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    // Monitor for instance A: compare each accepted head against the scoreboard
    always @(negedge clk_in) begin
        logic [101:0] e;
        if (tr_valid_a && tr_ready) begin
            if (q_a.size() == 0) begin
                chk_cnt++;
                $display("FAIL a_unexpected_entry: got pc %08h, expected no entry", tr_pc_a);
            end else begin
                e = q_a.pop_front();
                check("a_entry", {26'd0, tr_pc_a, tr_ir_a, tr_rf_w_a, tr_rd_a, tr_wdata_a}, {26'd0, e});
            end
        end
    end

    // Monitor for instance B
    always @(negedge clk_in) begin
        logic [101:0] e;
        if (tr_valid_b && tr_ready) begin
            if (q_b.size() == 0) begin
                chk_cnt++;
                $display("FAIL b_unexpected_entry: got pc %08h, expected no entry", tr_pc_b);
            end else begin
                e = q_b.pop_front();
                check("b_entry", {26'd0, tr_pc_b, tr_ir_b, tr_rf_w_b, tr_rd_b, tr_wdata_b}, {26'd0, e});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        idle(2);
        reset = 1'b0;

        // Reset state
        check("rst_state_a", state_a, 0);
        check("rst_valid_a", tr_valid_a, 0);
        check("rst_count_a", count_a, 0);
        check("rst_flags_a", {done_a, overflow_a, drop_a}, 0);
        check("rst_head_a", tr_pc_a, 0);
        check("rst_state_b", state_b, 0);

        // Immediate trigger, stream with one bubble, consumer always ready
        trig_mode = 1'b0; tr_ready = 1'b1;
        arm_a = 1'b1; idle(1); arm_a = 1'b0;
        check("t1_armed", state_a, 1);
        check("t1_pre_valid", tr_valid_a, 0);
        issue(32'h00400000, 32'h00100093, 0, 1, 5'd1, 32'h1, 1, 0);
        check("t1_latency_valid", tr_valid_a, 1);
        check("t1_latency_pc", tr_pc_a, 32'h00400000);
        issue(32'h00400004, 32'h00200113, 0, 1, 5'd2, 32'h2, 1, 0);
        issue(32'h00400008, BUB,          0, 0, 5'd0, 32'h0, 0, 0);
        check("t1_count_bubble", count_a, 2);
        issue(32'h00400008, 32'h00308193, 0, 1, 5'd3, 32'h3, 1, 0);
        issue(32'h0040000c, 32'h00000013, 0, 0, 5'd0, 32'h0, 1, 0);
        check("t1_count", count_a, 4);
        check("t1_capture", state_a, 2);
        idle(4);
        check("t1_drained", q_a.size(), 0);
        check("t1_empty", tr_valid_a, 0);
        check("t1_hold_pc", tr_pc_a, 32'h0040000c);

        // PC-match trigger
        do_reset();
        trig_mode = 1'b1; trig_pc = 32'h0040000c;
        arm_a = 1'b1; idle(1); arm_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            pc = 32'h00400000 + 32'(4 * i);
            issue(pc, 32'h00000093 + 32'(i << 20), 0, 1, 5'(i + 1), 32'h0000a000 + 32'(i),
                  (i >= 3), 0);
            if (i == 2) begin
                check("t2_armed_state", state_a, 1);
                check("t2_armed_count", count_a, 0);
            end
            if (i == 3) check("t2_trig_count", count_a, 1);
        end
        check("t2_count", count_a, 4);
        idle(4);
        check("t2_drained", q_a.size(), 0);

        // Commit limit of five on instance B
        do_reset();
        trig_mode = 1'b0;
        arm_b = 1'b1; idle(1); arm_b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            issue(32'h00400100 + 32'(4 * i), 32'h00500013 + 32'(i), 0, 1, 5'd7,
                  32'hb0000000 + 32'(i), 0, (i < 5));
        end
        check("t3_state", state_b, 3);
        check("t3_done", done_b, 1);
        check("t3_count", count_b, 5);
        idle(4);
        check("t3_drained", q_b.size(), 0);
        // Second run without draining, then re-arm to flush
        tr_ready = 1'b0;
        arm_b = 1'b1; idle(1); arm_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(32'h00400140 + 32'(4 * i), 32'h00600013, 0, 0, 5'd0, 32'h0, 0, 0);
        end
        check("t3b_count", count_b, 5);
        check("t3b_overflow", {overflow_b, drop_b}, {1'b1, 16'd1});
        check("t3b_valid", tr_valid_b, 1);
        arm_b = 1'b1; idle(1); arm_b = 1'b0;
        check("t3_rearm_state", state_b, 1);
        check("t3_rearm_count", count_b, 0);
        check("t3_rearm_flags", {done_b, overflow_b, drop_b}, 0);
        check("t3_rearm_empty", tr_valid_b, 0);
        tr_ready = 1'b1;
        idle(3);

        // Overflow on instance A with a stalled consumer
        do_reset();
        tr_ready = 1'b0;
        arm_a = 1'b1; idle(1); arm_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            issue(32'h00400200 + 32'(4 * i), 32'h00700013 + 32'(i), 0, 1, 5'(i + 10),
                  32'hc0000000 + 32'(i), (i < 4), 0);
        end
        check("t4_count", count_a, 7);
        check("t4_overflow", overflow_a, 1);
        check("t4_drops", drop_a, 3);
        check("t4_head", tr_pc_a, 32'h00400200);
        tr_ready = 1'b1;
        issue(32'h0040021c, 32'h00800013, 0, 1, 5'd20, 32'hc0000007, 1, 0);
        check("t4_pop_no_drop", drop_a, 3);
        check("t4_count8", count_a, 8);
        idle(6);
        check("t4_drained", q_a.size(), 0);
        check("t4_empty", tr_valid_a, 0);

        // Stall repeats, then reset in the middle of a capture run
        do_reset();
        arm_a = 1'b1; idle(1); arm_a = 1'b0;
        issue(32'h00400020, 32'h00900093, 0, 1, 5'd1, 32'h9, 1, 0);
        repeat (3) issue(32'h00400020, 32'h00900093, 1, 1, 5'd1, 32'h9, 0, 0);
        check("t5_stall_count", count_a, 1);
        idle(3);
        check("t5_single_entry", q_a.size(), 0);
        tr_ready = 1'b0;
        issue(32'h00400024, 32'h00a00093, 0, 1, 5'd2, 32'ha, 0, 0);
        issue(32'h00400028, 32'h00b00093, 0, 1, 5'd3, 32'hb, 0, 0);
        check("t5_pre_rst_valid", tr_valid_a, 1);
        check("t5_pre_rst_state", state_a, 2);
        do_reset();
        check("t5_rst_valid", tr_valid_a, 0);
        check("t5_rst_state", state_a, 0);
        check("t5_rst_count", count_a, 0);
        tr_ready = 1'b1;
        idle(3);

        check("end_queue_a", q_a.size(), 0);
        check("end_queue_b", q_b.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
